// File: rtl/pkt_buffer_pkg.sv
// -----------------------------------------------------------------------------
// pkt_buffer_pkg
// Shared definitions for the packet buffer ingress writer and the downstream
// descriptor reader: address/rank widths, writer FSM state encoding, the
// packed packet descriptor, and a saturating length increment helper.
// -----------------------------------------------------------------------------
package pkt_buffer_pkg;

    localparam int ADDR_WIDTH = 12;
    localparam int PIFO_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } writer_state_t;

    // Field order is shared with the reader; rank occupies the MSBs.
    typedef struct packed {
        logic [PIFO_WIDTH-1:0] rank;
        logic [ADDR_WIDTH-1:0] sop_addr;
        logic [ADDR_WIDTH-1:0] len;
    } desc_t;

    // Packet length counter sticks at all-ones instead of wrapping.
    function automatic logic [ADDR_WIDTH-1:0] sat_inc(input logic [ADDR_WIDTH-1:0] v);
        logic [ADDR_WIDTH-1:0] r;
        if (v == {ADDR_WIDTH{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/pkt_buffer_writer_desc_fifo.sv
// -----------------------------------------------------------------------------
// desc_fifo
// Synchronous FIFO of packet descriptors. The head entry is read straight out
// of register storage, so descriptor fields are stable until popped.
// A push while full is accepted only when a pop happens in the same cycle.
//
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   push, push_data  write one descriptor
//   pop              remove the head descriptor (ignored when empty)
//   head             current head descriptor (zero after reset)
//   full, empty      occupancy flags decoded from the registered count
// -----------------------------------------------------------------------------
module desc_fifo
    import pkt_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rstn,
    input  logic  push,
    input  desc_t push_data,
    input  logic  pop,
    output desc_t head,
    output logic  full,
    output logic  empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    desc_t              mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W:0]     count_r;
    logic               push_ok_s;
    logic               pop_ok_s;

    assign full      = (count_r == (PTR_W+1)'(DEPTH));
    assign empty     = (count_r == {(PTR_W+1){1'b0}});
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign head      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pkt_buffer_writer.sv
// -----------------------------------------------------------------------------
// pkt_buffer_writer
// Ingress stage in front of the packet buffer. Writes AXI-Stream beats into
// the buffer at the free-list head, records the SOP address and rank, and
// queues a {rank, sop_addr, len} descriptor for the PIFO scheduler once the
// packet is complete. Packets starting while the buffer is almost full are
// consumed and dropped whole.
//
// Address and rank widths come from pkt_buffer_pkg so that the descriptor
// layout always matches the downstream reader.
//
// Optional build macro PKT_WRITER_STATS_EN adds stat_pkt_cnt / stat_drop_cnt.
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   s_axis_*                  ingress beat (tdata/tkeep/tuser/tpifo/tlast),
//                             tvalid/tready handshake
//   buf_wr_en, buf_*          buffer write strobe and passthrough write data
//   buf_fl_head               free-list head, used as the write address
//   buf_almost_full           buffer headroom flag, sampled at SOP only
//   m_desc_*                  descriptor stream to the PIFO scheduler
//   stat_pkt_cnt/drop_cnt     (PKT_WRITER_STATS_EN) descriptors pushed /
//                             packets dropped, wrapping 32-bit counters
// -----------------------------------------------------------------------------
module pkt_buffer_writer
    import pkt_buffer_pkg::*;
#(
    parameter int DATA_WIDTH    = 256,
    parameter int TUSER_WIDTH   = 128,
    parameter int DESC_DEPTH    = 4,
    parameter int MAX_PKT_WORDS = 48
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic [PIFO_WIDTH-1:0]   s_axis_tpifo,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic                    buf_wr_en,
    output logic [DATA_WIDTH-1:0]   buf_tdata,
    output logic [DATA_WIDTH/8-1:0] buf_tkeep,
    output logic [TUSER_WIDTH-1:0]  buf_tuser,
    output logic [PIFO_WIDTH-1:0]   buf_tpifo,
    output logic                    buf_tlast,
    input  logic [ADDR_WIDTH-1:0]   buf_fl_head,
    input  logic                    buf_almost_full,
    output logic                    m_desc_tvalid,
    input  logic                    m_desc_tready,
    output logic [ADDR_WIDTH-1:0]   m_desc_sop_addr,
    output logic [PIFO_WIDTH-1:0]   m_desc_rank,
    output logic [ADDR_WIDTH-1:0]   m_desc_len
`ifdef PKT_WRITER_STATS_EN
    ,
    output logic [31:0]             stat_pkt_cnt,
    output logic [31:0]             stat_drop_cnt
`endif
);

    // A legal packet length must be representable in the len field.
    if (MAX_PKT_WORDS < 1 || MAX_PKT_WORDS > (2**ADDR_WIDTH) - 1) begin : g_bad_max_pkt
        $error("MAX_PKT_WORDS does not fit the descriptor length field");
    end

    localparam logic [ADDR_WIDTH-1:0] LEN_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    writer_state_t          state_r;
    logic [ADDR_WIDTH-1:0]  sop_addr_r;
    logic [PIFO_WIDTH-1:0]  rank_r;
    logic [ADDR_WIDTH-1:0]  len_r;

    logic                   accept_s;
    logic                   push_s;
    desc_t                  push_desc_s;
    logic                   sop_drop_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    desc_t                  head_s;

    // Write data goes straight to the buffer; only the strobe is qualified.
    assign buf_tdata = s_axis_tdata;
    assign buf_tkeep = s_axis_tkeep;
    assign buf_tuser = s_axis_tuser;
    assign buf_tpifo = s_axis_tpifo;
    assign buf_tlast = s_axis_tlast;

    assign accept_s = s_axis_tvalid & s_axis_tready;

    // Ingress ready: descriptor space is only checked when a new packet starts.
    always_comb begin
        s_axis_tready = 1'b0;
        if (!rstn) begin
            s_axis_tready = 1'b0;
        end else begin
            case (state_r)
                IDLE:        s_axis_tready = ~fifo_full_s;
                WRITE, DROP: s_axis_tready = 1'b1;
                default:     s_axis_tready = 1'b0;
            endcase
        end
    end

    // Write strobe, drop detection and descriptor push for the accepted beat.
    always_comb begin
        buf_wr_en   = 1'b0;
        push_s      = 1'b0;
        push_desc_s = '0;
        sop_drop_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && buf_almost_full) begin
                    sop_drop_s = 1'b1;
                end else if (accept_s) begin
                    buf_wr_en            = 1'b1;
                    push_s               = s_axis_tlast;
                    push_desc_s.rank     = s_axis_tpifo;
                    push_desc_s.sop_addr = buf_fl_head;
                    push_desc_s.len      = LEN_ONE;
                end else begin
                    buf_wr_en = 1'b0;
                end
            end
            WRITE: begin
                if (accept_s) begin
                    buf_wr_en            = 1'b1;
                    push_s               = s_axis_tlast;
                    push_desc_s.rank     = rank_r;
                    push_desc_s.sop_addr = sop_addr_r;
                    push_desc_s.len      = sat_inc(len_r);
                end else begin
                    buf_wr_en = 1'b0;
                end
            end
            default: begin
                buf_wr_en = 1'b0;
            end
        endcase
    end

    // Packet FSM and SOP context capture.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r    <= IDLE;
            sop_addr_r <= {ADDR_WIDTH{1'b0}};
            rank_r     <= {PIFO_WIDTH{1'b0}};
            len_r      <= {ADDR_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        if (buf_almost_full) begin
                            state_r <= s_axis_tlast ? IDLE : DROP;
                        end else begin
                            sop_addr_r <= buf_fl_head;
                            rank_r     <= s_axis_tpifo;
                            len_r      <= LEN_ONE;
                            state_r    <= s_axis_tlast ? IDLE : WRITE;
                        end
                    end
                end
                WRITE: begin
                    // almost_full is ignored here: the headroom covers a max packet.
                    if (accept_s) begin
                        len_r <= sat_inc(len_r);
                        if (s_axis_tlast) begin
                            state_r <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (accept_s && s_axis_tlast) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // A push at tlast cannot overflow: space was checked at SOP and the FIFO
    // only drains while the packet is in flight.
    desc_fifo #(
        .DEPTH(DESC_DEPTH)
    ) u_desc_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push_s),
        .push_data (push_desc_s),
        .pop       (m_desc_tready),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign m_desc_tvalid   = ~fifo_empty_s;
    assign m_desc_rank     = head_s.rank;
    assign m_desc_sop_addr = head_s.sop_addr;
    assign m_desc_len      = head_s.len;

`ifdef PKT_WRITER_STATS_EN
    logic [31:0] pkt_cnt_r;
    logic [31:0] drop_cnt_r;

    // Wrapping packet and drop counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pkt_cnt_r  <= 32'd0;
            drop_cnt_r <= 32'd0;
        end else begin
            if (push_s) begin
                pkt_cnt_r <= pkt_cnt_r + 32'd1;
            end
            if (sop_drop_s) begin
                drop_cnt_r <= drop_cnt_r + 32'd1;
            end
        end
    end

    assign stat_pkt_cnt  = pkt_cnt_r;
    assign stat_drop_cnt = drop_cnt_r;
`else
    logic unused_s;
    assign unused_s = sop_drop_s;
`endif

endmodule

// File: tb/tb_pkt_buffer_writer.sv
// -----------------------------------------------------------------------------
// tb_pkt_buffer_writer
// Directed bench for pkt_buffer_writer: drives beats right after the rising
// edge and samples outputs 1-5 time units later, away from the clock edge.
// -----------------------------------------------------------------------------
module tb_pkt_buffer_writer;

    logic         clk = 1'b0;
    logic         rstn;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tkeep;
    logic [127:0] s_axis_tuser;
    logic [31:0]  s_axis_tpifo;
    logic         s_axis_tlast;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         buf_wr_en;
    logic [255:0] buf_tdata;
    logic [31:0]  buf_tkeep;
    logic [127:0] buf_tuser;
    logic [31:0]  buf_tpifo;
    logic         buf_tlast;
    logic [11:0]  buf_fl_head;
    logic         buf_almost_full;
    logic         m_desc_tvalid;
    logic         m_desc_tready;
    logic [11:0]  m_desc_sop_addr;
    logic [31:0]  m_desc_rank;
    logic [11:0]  m_desc_len;
`ifdef PKT_WRITER_STATS_EN
    logic [31:0]  stat_pkt_cnt;
    logic [31:0]  stat_drop_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pkt_buffer_writer dut (
        .clk             (clk),
        .rstn            (rstn),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tkeep    (s_axis_tkeep),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tpifo    (s_axis_tpifo),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .buf_wr_en       (buf_wr_en),
        .buf_tdata       (buf_tdata),
        .buf_tkeep       (buf_tkeep),
        .buf_tuser       (buf_tuser),
        .buf_tpifo       (buf_tpifo),
        .buf_tlast       (buf_tlast),
        .buf_fl_head     (buf_fl_head),
        .buf_almost_full (buf_almost_full),
        .m_desc_tvalid   (m_desc_tvalid),
        .m_desc_tready   (m_desc_tready),
        .m_desc_sop_addr (m_desc_sop_addr),
        .m_desc_rank     (m_desc_rank),
        .m_desc_len      (m_desc_len)
`ifdef PKT_WRITER_STATS_EN
        ,
        .stat_pkt_cnt    (stat_pkt_cnt),
        .stat_drop_cnt   (stat_drop_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one beat, check the same-cycle outputs, let it be accepted.
    task automatic beat(input string tag, input logic [63:0] data, input logic [31:0] pifo,
                        input logic last, input logic [11:0] head, input logic exp_wr);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {4{data}};
        s_axis_tkeep  = 32'hFFFF_FFFF;
        s_axis_tuser  = {2{data}};
        s_axis_tpifo  = pifo;
        s_axis_tlast  = last;
        buf_fl_head   = head;
        #4;
        chk({tag, ".rdy"}, 64'(s_axis_tready), 64'd1);
        chk({tag, ".wr"},  64'(buf_wr_en), 64'(exp_wr));
        chk({tag, ".dat"}, buf_tdata[63:0], data);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic chk_desc(input string tag, input logic vld, input logic [31:0] rank,
                            input logic [11:0] addr, input logic [11:0] len);
        chk({tag, ".vld"},  64'(m_desc_tvalid), 64'(vld));
        chk({tag, ".rank"}, 64'(m_desc_rank), 64'(rank));
        chk({tag, ".addr"}, 64'(m_desc_sop_addr), 64'(addr));
        chk({tag, ".len"},  64'(m_desc_len), 64'(len));
    endtask

    task automatic pop_one();
        m_desc_tready = 1'b1;
        @(posedge clk); #1;
        m_desc_tready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] drain_rank [4];

        rstn            = 1'b0;
        s_axis_tvalid   = 1'b1;
        s_axis_tdata    = '0;
        s_axis_tkeep    = '0;
        s_axis_tuser    = '0;
        s_axis_tpifo    = 32'd0;
        s_axis_tlast    = 1'b0;
        buf_fl_head     = 12'd0;
        buf_almost_full = 1'b0;
        m_desc_tready   = 1'b0;

        // Reset state, with tvalid held high to show nothing is accepted.
        repeat (3) @(posedge clk);
        #1;
        chk("rst.rdy", 64'(s_axis_tready), 64'd0);
        chk("rst.wr",  64'(buf_wr_en), 64'd0);
        chk_desc("rst", 1'b0, 32'd0, 12'd0, 12'd0);
`ifdef PKT_WRITER_STATS_EN
        chk("rst.pkts",  64'(stat_pkt_cnt), 64'd0);
        chk("rst.drops", 64'(stat_drop_cnt), 64'd0);
`endif
        rstn          = 1'b1;
        s_axis_tvalid = 1'b0;
        #1;
        chk("post_rst.rdy", 64'(s_axis_tready), 64'd1);
        @(posedge clk); #1;

        // 3-word packet, rank 0x10, SOP at address 5.
        beat("t1.b0", 64'hA0, 32'h10, 1'b0, 12'd5, 1'b1);
        chk("t1.mid_vld", 64'(m_desc_tvalid), 64'd0);
        beat("t1.b1", 64'hA1, 32'h10, 1'b0, 12'd6, 1'b1);
        beat("t1.b2", 64'hA2, 32'h10, 1'b1, 12'd7, 1'b1);
        chk_desc("t1.desc", 1'b1, 32'h10, 12'd5, 12'd3);
        pop_one();
        chk("t1.popped", 64'(m_desc_tvalid), 64'd0);

        // Single-word packets stay in IDLE: the next beat is a fresh SOP.
        beat("t2.b0", 64'hB0, 32'hABCD, 1'b1, 12'h7FF, 1'b1);
        chk_desc("t2.desc", 1'b1, 32'hABCD, 12'h7FF, 12'd1);
        pop_one();
        beat("t2.c0", 64'hB1, 32'h22, 1'b1, 12'h100, 1'b1);
        chk_desc("t2.desc2", 1'b1, 32'h22, 12'h100, 12'd1);
        pop_one();

        // almost_full at SOP: 4-word packet consumed without writes, then a
        // single-word dropped packet.
        buf_almost_full = 1'b1;
        beat("t3.b0", 64'hC0, 32'h33, 1'b0, 12'h010, 1'b0);
        beat("t3.b1", 64'hC1, 32'h33, 1'b0, 12'h010, 1'b0);
        beat("t3.b2", 64'hC2, 32'h33, 1'b0, 12'h010, 1'b0);
        beat("t3.b3", 64'hC3, 32'h33, 1'b1, 12'h010, 1'b0);
        chk("t3.vld", 64'(m_desc_tvalid), 64'd0);
        beat("t3.s0", 64'hC4, 32'h34, 1'b1, 12'h010, 1'b0);
        chk("t3.vld2", 64'(m_desc_tvalid), 64'd0);
        buf_almost_full = 1'b0;

        // almost_full rising mid-packet is ignored.
        beat("t4.b0", 64'hD0, 32'h55, 1'b0, 12'h200, 1'b1);
        buf_almost_full = 1'b1;
        beat("t4.b1", 64'hD1, 32'h55, 1'b0, 12'h201, 1'b1);
        beat("t4.b2", 64'hD2, 32'h55, 1'b0, 12'h202, 1'b1);
        beat("t4.b3", 64'hD3, 32'h55, 1'b0, 12'h203, 1'b1);
        beat("t4.b4", 64'hD4, 32'h55, 1'b1, 12'h204, 1'b1);
        buf_almost_full = 1'b0;
        chk_desc("t4.desc", 1'b1, 32'h55, 12'h200, 12'd5);
        pop_one();

        // Fill the descriptor FIFO with four 2-word packets.
        drain_rank[0] = 32'hE2;
        drain_rank[1] = 32'hE3;
        drain_rank[2] = 32'hE4;
        drain_rank[3] = 32'h99;
        for (int p = 0; p < 4; p++) begin
            beat("t5.b0", 64'hE0 + 64'(p), 32'hE1 + 32'(p), 1'b0, 12'h210 + 12'(p * 16), 1'b1);
            beat("t5.b1", 64'hF0 + 64'(p), 32'hE1 + 32'(p), 1'b1, 12'h211 + 12'(p * 16), 1'b1);
        end
        chk_desc("t5.head", 1'b1, 32'hE1, 12'h210, 12'd2);
        // FIFO full: the next SOP is held off until one descriptor is popped.
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {4{64'h99}};
        s_axis_tpifo  = 32'h99;
        s_axis_tlast  = 1'b1;
        buf_fl_head   = 12'h300;
        m_desc_tready = 1'b1;
        #4;
        chk("t5.full_rdy", 64'(s_axis_tready), 64'd0);
        chk("t5.full_wr",  64'(buf_wr_en), 64'd0);
        @(posedge clk); #1;
        m_desc_tready = 1'b0;
        #4;
        chk("t5.reopen_rdy", 64'(s_axis_tready), 64'd1);
        chk("t5.reopen_wr",  64'(buf_wr_en), 64'd1);
        @(posedge clk); #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        chk("t5.refull_rdy", 64'(s_axis_tready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk("t5.drain_vld",  64'(m_desc_tvalid), 64'd1);
            chk("t5.drain_rank", 64'(m_desc_rank), 64'(drain_rank[k]));
            pop_one();
        end
        chk("t5.empty", 64'(m_desc_tvalid), 64'd0);
`ifdef PKT_WRITER_STATS_EN
        chk("t5.pkts",  64'(stat_pkt_cnt), 64'd9);
        chk("t5.drops", 64'(stat_drop_cnt), 64'd2);
`endif

        // Reset mid-packet abandons it; the next packet starts cleanly.
        beat("t6.b0", 64'h70, 32'h77, 1'b0, 12'h400, 1'b1);
        beat("t6.b1", 64'h71, 32'h77, 1'b0, 12'h401, 1'b1);
        rstn          = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b1;
        #4;
        chk("t6.rst_rdy", 64'(s_axis_tready), 64'd0);
        chk("t6.rst_wr",  64'(buf_wr_en), 64'd0);
        @(posedge clk); #1;
        rstn          = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        chk_desc("t6.after_rst", 1'b0, 32'd0, 12'd0, 12'd0);
        beat("t6.n0", 64'h80, 32'h88, 1'b0, 12'h500, 1'b1);
        beat("t6.n1", 64'h81, 32'h88, 1'b1, 12'h501, 1'b1);
        chk_desc("t6.desc", 1'b1, 32'h88, 12'h500, 12'd2);
`ifdef PKT_WRITER_STATS_EN
        chk("t6.pkts",  64'(stat_pkt_cnt), 64'd1);
        chk("t6.drops", 64'(stat_drop_cnt), 64'd0);
`endif
        pop_one();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pkt_buffer_writer.md
# pkt_buffer_writer

Ingress stage directly upstream of the packet buffer / free-list address manager. Accepts AXI-Stream packets with a per-packet PIFO rank, drives the buffer write strobe and data, and records the start-of-packet (SOP) buffer address taken from the free-list head. When a packet is fully written, it emits a descriptor {rank, sop_addr, len} towards the PIFO scheduler. Packets arriving while the buffer is almost full are dropped whole.

## Interface
- ADDR_WIDTH, 12, buffer address width
- DATA_WIDTH, 256, tdata width; tkeep is DATA_WIDTH/8
- TUSER_WIDTH, 128, tuser width
- PIFO_WIDTH, 32, rank width
- DESC_DEPTH, 4, descriptor FIFO depth (power of two, ≥2)
- MAX_PKT_WORDS, 48, largest legal packet in words; must not exceed the buffer almost-full headroom

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- s_axis_tdata/tkeep/tuser/tpifo/tlast  in  DATA_WIDTH/DATA_WIDTH/8/TUSER_WIDTH/PIFO_WIDTH/1  ingress beat
- s_axis_tvalid  in  1  ingress valid
- s_axis_tready  out  1  ingress ready
- buf_wr_en  out  1  buffer write strobe; advances free-list head
- buf_tdata/tkeep/tuser/tpifo/tlast  out  as ingress  data to buffer
- buf_fl_head  in  ADDR_WIDTH  current free-list head (write address)
- buf_almost_full  in  1  buffer almost-full flag
- m_desc_tvalid  out  1  descriptor valid
- m_desc_tready  in  1  descriptor accepted by PIFO
- m_desc_sop_addr  out  ADDR_WIDTH  SOP address
- m_desc_rank  out  PIFO_WIDTH  rank captured at SOP
- m_desc_len  out  ADDR_WIDTH  packet length in words

## Operation
- FSM states: IDLE (expecting SOP), WRITE, DROP.
- IDLE: tready = ~desc_full. On an accepted beat (tvalid & tready):
  - If buf_almost_full: enter DROP, unless tlast is set, in which case stay in IDLE. buf_wr_en=0. Increment drop count.
  - Otherwise: buf_wr_en=1. Latch sop_addr=buf_fl_head, rank=s_axis_tpifo, len=1.
    - If tlast: push the descriptor and stay in IDLE.
    - Else: enter WRITE.
- WRITE: tready=1. Each accepted beat asserts buf_wr_en and increments len.
  - len saturates at all-ones.
  - On tlast, push descriptor {rank, sop_addr, len} and return to IDLE.
  - almost_full is ignored mid-packet; the headroom guarantees space.
- DROP: tready=1, buf_wr_en=0. Beats are consumed. tlast returns to IDLE.
- Descriptor space is checked only at SOP. The FIFO can only drain while a packet is in flight, so a push at tlast never overflows.
- buf_* data outputs are combinational passthrough of s_axis_*.
- Descriptor FIFO pop occurs on m_desc_tvalid & m_desc_tready. Push and pop in the same cycle on a full FIFO are legal.

## Timing
- buf_wr_en and buf data: same cycle as the accepted beat (0 latency).
- Descriptor: m_desc_tvalid rises the cycle after the tlast beat is accepted. Fields are stable until popped.
- Back-to-back packets: a new SOP may be accepted the cycle after tlast. No bubble is required.
- Reset values:
  - state=IDLE
  - s_axis_tready=0 while rstn low
  - buf_wr_en=0
  - m_desc_tvalid=0
  - descriptor fields 0
  - FIFO empty
  - counters 0
- Reset mid-packet: the partial packet is abandoned and no descriptor is emitted. Address-manager cleanup is the buffer's own reset.

## Configuration
- PKT_WRITER_STATS_EN defined: adds output ports stat_pkt_cnt (32b, descriptors pushed) and stat_drop_cnt (32b, packets dropped). Both wrap modulo 2^32 and reset to 0.
- Undefined: no counters and no stat ports.

## Structure
- Shared package pkt_buffer_pkg holds:
  - ADDR_WIDTH/PIFO_WIDTH constants
  - writer state enum {IDLE, WRITE, DROP}
  - packed desc_t {rank, sop_addr, len}, reused by the downstream reader.
- One sub-module: desc_fifo, a synchronous FIFO of desc_t with full/empty flags and a registered output.

## Test plan
- 3-word packet, rank 0x10, fl_head=5 → buf_wr_en for 3 cycles; descriptor {0x10, 5, 3} valid one cycle after tlast.
- Single-word packet (SOP=tlast), fl_head=0x7FF → descriptor {rank, 0x7FF, 1}; FSM stays IDLE.
- almost_full=1 at SOP of a 4-word packet → 4 beats consumed, buf_wr_en never asserted, no descriptor, drop count +1.
- almost_full rises on word 2 of 5 → all 5 words written; descriptor len=5.
- m_desc_tready=0 with 4 packets sent → after the 4th descriptor, tready=0 at the next SOP. Popping one descriptor re-enables tready the following cycle.
- rstn pulsed low during WRITE → outputs return to reset values; the next packet yields a correct descriptor with a fresh sop_addr.
